// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clock_pkg
// Purpose : Shared constants, set-mode state type and field helpers for the
//           digital clock time-set path.
// Rev     : 1.0  initial release
// ============================================================================
package clock_pkg;

  localparam logic [7:0] HOUR_MAX = 8'd23;
  localparam logic [7:0] MIN_MAX  = 8'd59;
  localparam logic [7:0] SEC_MAX  = 8'd59;

  // Byte index of each field inside the packed time word
  localparam logic [1:0] FLD_H = 2'd2;
  localparam logic [1:0] FLD_M = 2'd1;
  localparam logic [1:0] FLD_S = 2'd0;

  typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} set_state_t;

  // Field edited in a given SET state (RUN has no active field)
  function automatic logic [1:0] field_of(set_state_t s);
    case (s)
      SET_H:   field_of = FLD_H;
      SET_M:   field_of = FLD_M;
      default: field_of = FLD_S;
    endcase
  endfunction

  function automatic logic [7:0] field_max(logic [1:0] fld);
    if (fld == FLD_H)      field_max = HOUR_MAX;
    else if (fld == FLD_M) field_max = MIN_MAX;
    else                   field_max = SEC_MAX;
  endfunction

  // One wrapping step up or down within 0..max
  function automatic logic [7:0] field_step(logic [7:0] v, logic [7:0] max, logic up);
    if (up) field_step = (v >= max) ? 8'd0 : v + 8'd1;
    else    field_step = (v == 8'd0) ? max : v - 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module  : key_debounce
// Purpose : 2-flop synchroniser, stable-time debounce and press pulse for one
//           active-low push key.
// Rev     : 1.0  initial release
// ============================================================================
module key_debounce #(
  parameter int DB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int              CNT_W    = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then accept a new level only after it persists DB_CYC cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      level  <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      press  <= 1'b0;
      if (sync_q[1] != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_q[1];
          cnt   <= '0;
          // Old level high means this update is a 1->0 transition
          press <= level;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : clock_set_ctrl
// Purpose : Time-set controller: debounces three keys, runs the set-mode FSM,
//           edits hour/min/sec, commits via a one-cycle load strobe and drives
//           per-field blink masks.
// Options : CLOCK_SET_AUTO_REPEAT_EN - 5 Hz auto-repeat of held inc/dec keys.
// Rev     : 1.0  initial release
// ============================================================================
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int BLINK_HZ    = 2,
  parameter int IDLE_S      = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode_n,
  input  logic        key_inc_n,
  input  logic        key_dec_n,
  input  logic [23:0] time_in,
  output logic        setting,
  output logic        load,
  output logic [23:0] time_load,
  output logic [2:0]  blink_mask
);

  localparam int DB_CYC   = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int HALF_CYC = CLK_FREQ / (2 * BLINK_HZ);
  localparam int IDLE_CYC = IDLE_S * CLK_FREQ;
  localparam int HALF_W   = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
  localparam int IDLE_W   = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);

  set_state_t       state;
  logic [23:0]      edit, edit_next;
  logic [IDLE_W-1:0] idle_cnt;
  logic [HALF_W-1:0] blink_cnt;
  logic             mode_lvl, inc_lvl, dec_lvl;
  logic             mode_ev, inc_ev, dec_ev;
  logic             inc_rep, dec_rep;
  logic             inc_act, dec_act, any_ev;
  logic [1:0]       fld;
  logic [2:0]       fld_bit;

  key_debounce #(.DB_CYC(DB_CYC)) u_db_mode (
    .clk(clk), .rst_n(rst_n), .key_n(key_mode_n), .level(mode_lvl), .press(mode_ev));
  key_debounce #(.DB_CYC(DB_CYC)) u_db_inc (
    .clk(clk), .rst_n(rst_n), .key_n(key_inc_n), .level(inc_lvl), .press(inc_ev));
  key_debounce #(.DB_CYC(DB_CYC)) u_db_dec (
    .clk(clk), .rst_n(rst_n), .key_n(key_dec_n), .level(dec_lvl), .press(dec_ev));

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam int HOLD_CYC = CLK_FREQ;
  localparam int REP_CYC  = CLK_FREQ / 5;
  localparam int HOLD_W   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_one, rep_tick;
  logic              unused_lvl;

  // Exactly one of inc/dec held while editing; both held suppresses repeat
  assign hold_one   = setting && (inc_lvl != dec_lvl);
  assign rep_tick   = hold_one && (hold_cnt == HOLD_W'(HOLD_CYC - 1));
  assign inc_rep    = rep_tick & ~inc_lvl;
  assign dec_rep    = rep_tick & ~dec_lvl;
  assign unused_lvl = mode_lvl;

  // Hold timer: first repeat after 1 s, then rewinds so repeats come every REP_CYC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        hold_cnt <= '0;
    else if (!hold_one) hold_cnt <= '0;
    else if (rep_tick)  hold_cnt <= HOLD_W'(HOLD_CYC - REP_CYC);
    else                hold_cnt <= hold_cnt + 1'b1;
  end
`else
  logic unused_lvl;

  assign inc_rep    = 1'b0;
  assign dec_rep    = 1'b0;
  assign unused_lvl = &{mode_lvl, inc_lvl, dec_lvl};
`endif

  assign inc_act = inc_ev | inc_rep;
  assign dec_act = dec_ev | dec_rep;
  assign any_ev  = mode_ev | inc_act | dec_act;
  assign fld     = field_of(state);
  assign fld_bit = 3'b001 << fld;

  // Edit register with the active field stepped in the requested direction
  always_comb begin
    edit_next = edit;
    edit_next[{fld, 3'b000} +: 8] = field_step(edit[{fld, 3'b000} +: 8], field_max(fld), inc_act);
  end

  // Set-mode FSM with edit register, idle timeout and blink phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      setting    <= 1'b0;
      load       <= 1'b0;
      time_load  <= '0;
      blink_mask <= '0;
      edit       <= '0;
      idle_cnt   <= '0;
      blink_cnt  <= '0;
    end else begin
      load <= 1'b0;
      if (state == RUN) begin
        setting    <= 1'b0;
        blink_mask <= '0;
        idle_cnt   <= '0;
        blink_cnt  <= '0;
        if (mode_ev) begin
          edit    <= time_in;
          state   <= SET_H;
          setting <= 1'b1;
        end
      end else if (mode_ev) begin
        // Mode wins over any simultaneous inc/dec
        idle_cnt   <= '0;
        blink_cnt  <= '0;
        blink_mask <= '0;
        if (state == SET_S) begin
          state     <= RUN;
          setting   <= 1'b0;
          load      <= 1'b1;
          time_load <= edit;
        end else begin
          state <= (state == SET_H) ? SET_M : SET_S;
        end
      end else if (any_ev) begin
        idle_cnt   <= '0;
        blink_cnt  <= '0;
        blink_mask <= '0;
        if (inc_act != dec_act) edit <= edit_next;
      end else if (idle_cnt == IDLE_LAST) begin
        // Abandon the edit; counter resumes from its held value
        state      <= RUN;
        setting    <= 1'b0;
        blink_mask <= '0;
        idle_cnt   <= '0;
        blink_cnt  <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
        if (blink_cnt == HALF_LAST) begin
          blink_cnt  <= '0;
          blink_mask <= blink_mask ^ fld_bit;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_clock_set_ctrl
// Purpose : Self-checking bench for clock_set_ctrl against an event-level
//           reference model of the set-mode behaviour.
// Rev     : 1.0  initial release
// ============================================================================
module tb_clock_set_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_mode_n = 1'b1;
  logic        key_inc_n = 1'b1;
  logic        key_dec_n = 1'b1;
  logic [23:0] time_in = '0;
  logic        setting, load;
  logic [23:0] time_load;
  logic [2:0]  blink_mask;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: state 0=RUN 1=SET_H 2=SET_M 3=SET_S; f[0..2]=hour,min,sec
  int          m_state = 0;
  int          m_f[3];
  int          exp_loads = 0;
  logic [23:0] exp_val = '0;
  int          load_cnt = 0;
  logic [23:0] last_load = '0;

  clock_set_ctrl #(
    .CLK_FREQ(1000), .DEBOUNCE_MS(2), .BLINK_HZ(50), .IDLE_S(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .key_mode_n(key_mode_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
    .time_in(time_in),
    .setting(setting), .load(load), .time_load(time_load), .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Count every load strobe and the word it carried
  always @(posedge clk) begin
    #1;
    if (load === 1'b1) begin
      load_cnt++;
      last_load = time_load;
      check("setting_at_load", {31'd0, setting}, 32'd0);
    end
  end

  task automatic model_apply(input bit m, input bit i, input bit d);
    int k, md;
    if (m_state == 0) begin
      if (m) begin
        m_f[0] = time_in[23:16];
        m_f[1] = time_in[15:8];
        m_f[2] = time_in[7:0];
        m_state = 1;
      end
    end else if (m) begin
      if (m_state == 3) begin
        exp_loads++;
        exp_val = {8'(m_f[0]), 8'(m_f[1]), 8'(m_f[2])};
        m_state = 0;
      end else begin
        m_state++;
      end
    end else if (i != d) begin
      k  = m_state - 1;
      md = (k == 0) ? 24 : 60;
      m_f[k] = i ? (m_f[k] + 1) % md : (m_f[k] + md - 1) % md;
    end
  endtask

  function automatic logic [2:0] active_bit();
    case (m_state)
      1: return 3'b100;
      2: return 3'b010;
      3: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic check_state();
    check("setting", {31'd0, setting}, {31'd0, m_state != 0});
    check("load_count", load_cnt, exp_loads);
    if (exp_loads > 0) check("time_load", {8'd0, last_load}, {8'd0, exp_val});
    check("mask_field", {29'd0, blink_mask & ~active_bit()}, 32'd0);
  endtask

  // Drive a clean press; returns just after the edge where the FSM reacts
  task automatic press_at(input bit m, input bit i, input bit d);
    @(negedge clk);
    key_mode_n = ~m;
    key_inc_n  = ~i;
    key_dec_n  = ~d;
    repeat (5) @(posedge clk);
    #2;
    key_mode_n = 1'b1;
    key_inc_n  = 1'b1;
    key_dec_n  = 1'b1;
    model_apply(m, i, d);
  endtask

  task automatic press(input bit m, input bit i, input bit d);
    press_at(m, i, d);
    repeat (12) @(posedge clk);
    #2;
    check_state();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int r;
    m_f[0] = 0; m_f[1] = 0; m_f[2] = 0;
    wait_cyc(3);
    check("rst_setting", {31'd0, setting}, 32'd0);
    check("rst_load", {31'd0, load}, 32'd0);
    check("rst_time_load", {8'd0, time_load}, 32'd0);
    check("rst_mask", {29'd0, blink_mask}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(4);

    // One-cycle bounce must not register
    time_in = 24'h0A1E05;
    @(negedge clk);
    key_mode_n = 1'b0;
    @(negedge clk);
    key_mode_n = 1'b1;
    wait_cyc(12);
    check("bounce_ignored", {31'd0, setting}, 32'd0);

    // Clean press enters SET_H; blink phase timing for the hour field
    press_at(1'b1, 1'b0, 1'b0);
    check("enter_set_h", {31'd0, setting}, 32'd1);
    check("mask_at_entry", {29'd0, blink_mask}, 32'd0);
    wait_cyc(5);
    check("blink_visible", {29'd0, blink_mask}, 32'd0);
    wait_cyc(10);
    check("blink_hidden", {29'd0, blink_mask}, 32'h4);
    wait_cyc(10);
    check("blink_visible2", {29'd0, blink_mask}, 32'd0);

    // Full cycle with two increments in SET_M -> 0x0A2005
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("full_cycle_value", {8'd0, last_load}, 32'h000A2005);

    // Hour wrap up and minute wrap down
    time_in = 24'h170000;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("wrap_value", {8'd0, last_load}, 32'h00003B00);

    // Mode+inc together, then inc+dec together
    time_in = 24'h0C2211;
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("simul_value", {8'd0, last_load}, 32'h000C2211);

    // Idle timeout from SET_S returns to RUN without a load
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press_at(1'b1, 1'b0, 1'b0);
    wait_cyc(990);
    check("idle_still_set", {31'd0, setting}, 32'd1);
    wait_cyc(20);
    m_state = 0;
    check("idle_dropped", {31'd0, setting}, 32'd0);
    check("idle_no_load", load_cnt, exp_loads);
    check("idle_mask", {29'd0, blink_mask}, 32'd0);

    // Randomised key traffic
    for (int n = 0; n < 60; n++) begin
      time_in = {8'($urandom_range(0, 23)), 8'($urandom_range(0, 59)), 8'($urandom_range(0, 59))};
      r = $urandom_range(0, 9);
      if (r <= 2)      press(1'b1, 1'b0, 1'b0);
      else if (r <= 5) press(1'b0, 1'b1, 1'b0);
      else if (r <= 7) press(1'b0, 1'b0, 1'b1);
      else if (r == 8) press(1'b0, 1'b1, 1'b1);
      else             press(1'b1, 1'b1, 1'b0);
    end

    // Reset in the middle of SET_M: no load, everything back to idle
    if (m_state != 0) begin
      while (m_state != 0) press(1'b1, 1'b0, 1'b0);
    end
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    m_state = 0;
    check("rst_mid_setting", {31'd0, setting}, 32'd0);
    check("rst_mid_load", {31'd0, load}, 32'd0);
    check("rst_mid_mask", {29'd0, blink_mask}, 32'd0);
    wait_cyc(3);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(20);
    check("rst_mid_no_load", load_cnt, exp_loads);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
